// File: rtl/conv_mdc_hwpe_if.sv
// conv_mdc_hwpe_if: TCDM master ports and register target port of the convolution accelerator.
// The accelerator connects through the master modport; memory and host connect through slave.
interface conv_mdc_hwpe_if #(
   parameter int MP = 2,
   parameter int ID = 10
);
   logic [MP-1:0]       tcdm_req;
   logic [MP-1:0]       tcdm_gnt;
   logic [MP-1:0][31:0] tcdm_add;
   logic [MP-1:0]       tcdm_wen;
   logic [MP-1:0][3:0]  tcdm_be;
   logic [MP-1:0][31:0] tcdm_data;
   logic [MP-1:0][31:0] tcdm_r_data;
   logic [MP-1:0]       tcdm_r_valid;
   logic                periph_req;
   logic [31:0]         periph_add;
   logic                periph_wen;
   logic [3:0]          periph_be;
   logic [31:0]         periph_data;
   logic [ID-1:0]       periph_id;
   logic                periph_gnt;
   logic [31:0]         periph_r_data;
   logic                periph_r_valid;
   logic [ID-1:0]       periph_r_id;

   modport master (
      output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
      input  tcdm_gnt, tcdm_r_data, tcdm_r_valid,
      input  periph_req, periph_add, periph_wen, periph_be, periph_data, periph_id,
      output periph_gnt, periph_r_data, periph_r_valid, periph_r_id
   );

   modport slave (
      input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
      output tcdm_gnt, tcdm_r_data, tcdm_r_valid,
      output periph_req, periph_add, periph_wen, periph_be, periph_data, periph_id,
      input  periph_gnt, periph_r_data, periph_r_valid, periph_r_id
   );
endinterface

// File: rtl/conv_mdc_hwpe.sv
// conv_mdc_hwpe: register-programmed 1-D integer convolution over TCDM (port 0 reads, port 1 writes).
module conv_mdc_hwpe #(
   parameter int N_CORES = 8,
   parameter int MP      = 2,
   parameter int ID      = 10
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       test_mode_i,
   output logic [N_CORES-1:0][1:0]    evt_o,
   conv_mdc_hwpe_if.master            bus
);
   typedef enum logic [2:0] {IDLE, LDW_REQ, LDW_WAIT, RD_REQ, RD_WAIT, WR_REQ, DONE} state_e;

   state_e         state_q;
   logic [31:0]    x_addr_q, w_addr_q, y_addr_q, acc_q, r_data_q;
   logic [15:0]    n_out_q, i_q;
   logic [3:0]     k_reg_q, k_q;
   logic [4:0]     shift_q;
   logic [31:0]    w_q [8];
   logic           r_valid_q;
   logic [ID-1:0]  r_id_q;
   logic [3:0]     k_eff;
   logic [7:0]     a;
   logic [31:0]    d, rd_val, prod;
   logic           busy, wr, rd, last_k, last_i;
   logic [MP-1:0]       req_v, wen_v;
   logic [MP-1:0][31:0] add_v, data_v;
   logic [MP-1:0][3:0]  be_v;
   logic           unused_ok;

   assign k_eff  = k_reg_q > 4'd8 ? 4'd8 : k_reg_q;
   assign a      = bus.periph_add[7:0];
   assign d      = bus.periph_data;
   assign busy   = state_q != IDLE;
   assign wr     = bus.periph_req & ~bus.periph_wen;
   assign rd     = bus.periph_req & bus.periph_wen;
   assign last_k = k_q == k_eff - 4'd1;
   assign last_i = i_q == n_out_q - 16'd1;
   assign prod   = w_q[k_q[2:0]] * bus.tcdm_r_data[0];

   always_comb
      rd_val = a == 8'h04 ? {32{busy}} :
               a == 8'h0C ? {31'd0, busy} :
               a == 8'h40 ? x_addr_q :
               a == 8'h44 ? w_addr_q :
               a == 8'h48 ? y_addr_q :
               a == 8'h4C ? {16'd0, n_out_q} :
               a == 8'h50 ? {28'd0, k_reg_q} :
               a == 8'h54 ? {27'd0, shift_q} : 32'd0;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q   <= IDLE;
         x_addr_q  <= '0;
         w_addr_q  <= '0;
         y_addr_q  <= '0;
         n_out_q   <= '0;
         k_reg_q   <= '0;
         shift_q   <= '0;
         acc_q     <= '0;
         i_q       <= '0;
         k_q       <= '0;
         r_valid_q <= 1'b0;
         r_id_q    <= '0;
         r_data_q  <= '0;
         for (int j = 0; j < 8; j++) w_q[j] <= '0;
      end else begin
         r_valid_q <= bus.periph_req;
         r_data_q  <= rd ? rd_val : 32'd0;
         if (bus.periph_req) r_id_q <= bus.periph_id;
         if (wr && !busy) begin
            if (a == 8'h40) x_addr_q <= d;
            if (a == 8'h44) w_addr_q <= d;
            if (a == 8'h48) y_addr_q <= d;
            if (a == 8'h4C) n_out_q  <= d[15:0];
            if (a == 8'h50) k_reg_q  <= d[3:0];
            if (a == 8'h54) shift_q  <= d[4:0];
         end
         case (state_q)
            IDLE:
               if (wr && a == 8'h00) begin
                  k_q     <= '0;
                  i_q     <= '0;
                  state_q <= (k_eff == 4'd0 || n_out_q == 16'd0) ? DONE : LDW_REQ;
               end
            LDW_REQ: if (bus.tcdm_gnt[0]) state_q <= LDW_WAIT;
            LDW_WAIT:
               if (bus.tcdm_r_valid[0]) begin
                  w_q[k_q[2:0]] <= bus.tcdm_r_data[0];
                  k_q     <= last_k ? 4'd0 : k_q + 4'd1;
                  state_q <= last_k ? RD_REQ : LDW_REQ;
               end
            RD_REQ: if (bus.tcdm_gnt[0]) state_q <= RD_WAIT;
            // first tap of every output restarts the accumulator
            RD_WAIT:
               if (bus.tcdm_r_valid[0]) begin
                  acc_q   <= (k_q == 4'd0 ? 32'd0 : acc_q) + prod;
                  k_q     <= last_k ? 4'd0 : k_q + 4'd1;
                  state_q <= last_k ? WR_REQ : RD_REQ;
               end
            WR_REQ:
               if (bus.tcdm_gnt[1]) begin
                  i_q     <= i_q + 16'd1;
                  state_q <= last_i ? DONE : RD_REQ;
               end
            default: state_q <= IDLE;
         endcase
         if (wr && a == 8'h14) state_q <= IDLE;
      end

   always_comb begin
      req_v  = '0;
      wen_v  = '0;
      be_v   = '0;
      add_v  = '0;
      data_v = '0;
      if (state_q == LDW_REQ || state_q == RD_REQ) begin
         req_v[0] = 1'b1;
         wen_v[0] = 1'b1;
         be_v[0]  = 4'hF;
         add_v[0] = state_q == LDW_REQ ? w_addr_q + (32'(k_q) << 2)
                                       : x_addr_q + ((32'(i_q) + 32'(k_q)) << 2);
      end
      if (state_q == WR_REQ) begin
         req_v[1]  = 1'b1;
         be_v[1]   = 4'hF;
         add_v[1]  = y_addr_q + (32'(i_q) << 2);
         data_v[1] = $signed(acc_q) >>> shift_q;
      end
   end

   assign bus.tcdm_req       = req_v;
   assign bus.tcdm_wen       = wen_v;
   assign bus.tcdm_be        = be_v;
   assign bus.tcdm_add       = add_v;
   assign bus.tcdm_data      = data_v;
   assign bus.periph_gnt     = bus.periph_req;
   assign bus.periph_r_data  = r_data_q;
   assign bus.periph_r_valid = r_valid_q;
   assign bus.periph_r_id    = r_id_q;
   assign evt_o              = state_q == DONE ? {N_CORES{2'b01}} : '0;
   assign unused_ok = ^{test_mode_i, bus.periph_add[31:8], bus.periph_be,
                        bus.tcdm_gnt, bus.tcdm_r_valid, bus.tcdm_r_data};
endmodule

// File: tb/tb_conv_mdc_hwpe.sv
// tb_conv_mdc_hwpe: random and directed convolution jobs against a TCDM memory model and a
// plain-arithmetic reference of the convolution and its cycle schedule.
module tb_conv_mdc_hwpe;
   localparam int NC = 8;
   localparam int ID = 10;
   localparam logic [31:0] XA = 32'h100, WA = 32'h200, YA = 32'h300;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic [NC-1:0][1:0] evt;
   logic [31:0] mem [0:1023];
   int xs [16];
   int ws [8];
   int cyc = 0, n_chk = 0, n_fail = 0;
   int n_stall = 0, n_wr = 0, n_req = 0, t_req = 0;
   bit stall_en = 0;
   bit pend = 0;
   logic [9:0] pend_a = '0;

   conv_mdc_hwpe_if #(.MP(2), .ID(ID)) bus ();

   conv_mdc_hwpe #(.N_CORES(NC), .MP(2), .ID(ID)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(1'b0), .evt_o(evt), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // zero-wait memory with optional random stalls; r_valid follows a granted read by one cycle
   initial begin
      bus.tcdm_gnt = '0;
      bus.tcdm_r_valid = '0;
      bus.tcdm_r_data = '0;
      forever begin
         @(negedge clk);
         bus.tcdm_r_valid = '0;
         if (pend) begin
            bus.tcdm_r_valid[0] = 1'b1;
            bus.tcdm_r_data[0] = mem[pend_a];
            pend = 0;
         end
         for (int p = 0; p < 2; p++) begin
            bus.tcdm_gnt[p] = bus.tcdm_req[p] && (!stall_en || $urandom_range(0, 9) != 0);
            if (bus.tcdm_req[p] && !bus.tcdm_gnt[p]) n_stall++;
         end
         if (|bus.tcdm_req) n_req++;
         if (bus.tcdm_req[0] && bus.tcdm_gnt[0]) begin
            pend = 1;
            pend_a = bus.tcdm_add[0][11:2];
         end
         if (bus.tcdm_req[1] && bus.tcdm_gnt[1]) begin
            mem[bus.tcdm_add[1][11:2]] = bus.tcdm_data[1];
            n_wr++;
         end
      end
   end

   task automatic reg_acc(input logic wen, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] q);
      logic [ID-1:0] id;
      id = ID'($urandom);
      @(negedge clk);
      bus.periph_req = 1'b1;
      bus.periph_wen = wen;
      bus.periph_add = {24'h0, a};
      bus.periph_data = d;
      bus.periph_id = id;
      t_req = cyc;
      #1 chk("p_gnt", 32'(bus.periph_gnt), 32'd1);
      @(negedge clk);
      bus.periph_req = 1'b0;
      q = bus.periph_r_data;
      chk("p_rvalid", 32'(bus.periph_r_valid), 32'd1);
      chk("p_rid", 32'(bus.periph_r_id), 32'(id));
      if (!wen) chk("p_wr_rdata", bus.periph_r_data, 32'd0);
   endtask

   task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] q;
      reg_acc(1'b0, a, d, q);
   endtask

   function automatic int ref_y(input int i, input int ke, input int sh);
      int acc = 0;
      for (int k = 0; k < ke; k++) acc += ws[k] * xs[i + k];
      return acc >>> sh;
   endfunction

   task automatic prog(input int k, input int n, input int sh);
      for (int j = 0; j < 16; j++) mem[XA[11:2] + 10'(j)] = xs[j];
      for (int j = 0; j < 8; j++) mem[WA[11:2] + 10'(j)] = ws[j];
      for (int j = 0; j < 8; j++) mem[YA[11:2] + 10'(j)] = 32'hDEADBEEF;
      reg_wr(8'h40, XA);
      reg_wr(8'h44, WA);
      reg_wr(8'h48, YA);
      reg_wr(8'h4C, 32'(n));
      reg_wr(8'h50, 32'(k));
      reg_wr(8'h54, 32'(sh));
   endtask

   task automatic run_job(input int k, input int n, input int sh, input bit stall);
      int ke, t0, exp_cyc;
      bit got;
      logic [31:0] q;
      ke = k > 8 ? 8 : k;
      prog(k, n, sh);
      stall_en = stall;
      n_stall = 0;
      n_wr = 0;
      n_req = 0;
      reg_wr(8'h00, 32'd0);
      t0 = t_req;
      got = 0;
      for (int c = 0; c < 3000 && !got; c++)
         if (evt[0][0]) got = 1;
         else @(negedge clk);
      chk("evt_seen", 32'(got), 32'd1);
      if (got) begin
         exp_cyc = (ke == 0 || n == 0) ? 1 : 2 * ke + n * (2 * ke + 1) + 1 + n_stall;
         chk("evt_cycle", 32'(cyc - t0), 32'(exp_cyc));
         chk("evt_all", 32'(evt), 32'({NC{2'b01}}));
         @(negedge clk);
         chk("evt_pulse", 32'(evt), 32'd0);
      end
      reg_acc(1'b1, 8'h0C, 32'd0, q);
      chk("status_idle", q, 32'd0);
      chk("n_writes", 32'(n_wr), 32'(ke == 0 ? 0 : n));
      if (ke == 0 || n == 0) chk("no_req", 32'(n_req), 32'd0);
      for (int i = 0; i < n && ke > 0; i++)
         chk("y_val", mem[YA[11:2] + 10'(i)], $unsigned(ref_y(i, ke, sh)));
      stall_en = 0;
   endtask

   task automatic set_basic();
      for (int j = 0; j < 16; j++) xs[j] = j + 1;
      ws = '{1, 2, 3, 0, 0, 0, 0, 0};
   endtask

   initial begin
      logic [31:0] q;
      bus.periph_req = 1'b0;
      bus.periph_wen = 1'b0;
      bus.periph_add = '0;
      bus.periph_be = 4'hF;
      bus.periph_data = '0;
      bus.periph_id = '0;
      for (int j = 0; j < 1024; j++) mem[j] = '0;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(bus.tcdm_req), 32'd0);
      chk("rst_evt", 32'(evt), 32'd0);
      chk("rst_rvalid", 32'(bus.periph_r_valid), 32'd0);
      rst_ni = 1'b1;
      reg_acc(1'b1, 8'h0C, 32'd0, q);
      chk("rst_status", q, 32'd0);
      reg_wr(8'h40, 32'h1000);
      reg_acc(1'b1, 8'h40, 32'd0, q);
      chk("x_addr_rb", q, 32'h1000);
      reg_acc(1'b1, 8'h04, 32'd0, q);
      chk("acquire_idle", q, 32'd0);
      reg_acc(1'b1, 8'h08, 32'd0, q);
      chk("unmapped_rd", q, 32'd0);

      set_basic();
      run_job(3, 4, 0, 0);
      chk("basic_y0", mem[YA[11:2]], 32'd14);
      chk("basic_y3", mem[YA[11:2] + 10'd3], 32'd32);
      run_job(3, 4, 0, 1);
      chk("stall_y1", mem[YA[11:2] + 10'd1], 32'd20);

      xs[0] = 5;
      ws[0] = -3;
      run_job(1, 1, 1, 0);
      chk("shift_sign", mem[YA[11:2]], 32'hFFFFFFF8);

      set_basic();
      run_job(3, 0, 0, 0);
      run_job(0, 3, 0, 0);

      for (int r = 0; r < 8; r++) begin
         for (int j = 0; j < 16; j++) xs[j] = $urandom;
         for (int j = 0; j < 8; j++) ws[j] = $urandom;
         run_job(int'($urandom_range(1, 10)), int'($urandom_range(1, 6)),
                 int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));
      end

      // abort in the middle of a long job
      prog(8, 6, 0);
      reg_wr(8'h00, 32'd0);
      repeat (10) @(negedge clk);
      reg_acc(1'b1, 8'h04, 32'd0, q);
      chk("acquire_busy", q, 32'hFFFFFFFF);
      reg_wr(8'h4C, 32'd5);
      reg_wr(8'h14, 32'd0);
      chk("clear_req", 32'(bus.tcdm_req), 32'd0);
      reg_acc(1'b1, 8'h0C, 32'd0, q);
      chk("clear_status", q, 32'd0);
      reg_acc(1'b1, 8'h4C, 32'd0, q);
      chk("busy_wr_ignored", q, 32'd6);

      prog(8, 6, 0);
      reg_wr(8'h00, 32'd0);
      repeat (7) @(negedge clk);
      rst_ni = 1'b0;
      #1;
      chk("arst_req", 32'(bus.tcdm_req), 32'd0);
      chk("arst_evt", 32'(evt), 32'd0);
      chk("arst_add", bus.tcdm_add[0], 32'd0);
      chk("arst_rvalid", 32'(bus.periph_r_valid), 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      reg_acc(1'b1, 8'h40, 32'd0, q);
      chk("arst_xaddr", q, 32'd0);
      set_basic();
      run_job(3, 4, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
